// File: rtl/zeta_addr_gen.sv
// rtl/zeta_addr_gen.sv - per-stage zeta ROM address generator for the pipelined NTT
module zeta_addr_gen #(
  parameter int STAGE_CNT = 8,
  parameter int STAGE_LAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  input  logic                                        in_last,
  output logic [1:0][STAGE_CNT-1:0][STAGE_CNT-2:0]    rom_addr,
  output logic [STAGE_CNT-1:0]                        addr_valid,
  output logic                                        poly_done,
  output logic                                        frame_err
);

  localparam int AW  = STAGE_CNT - 1;
  localparam int CW  = STAGE_CNT - 2;
  localparam int DLY = (STAGE_CNT - 1) * STAGE_LAT;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [DLY-1:0]       v_dly;
  logic [DLY-1:0]       l_dly;
  logic [STAGE_CNT-1:0] v_stg;
  logic [STAGE_CNT-1:0] l_stg;
  logic [CW-1:0]        cnt_q [STAGE_CNT];

  // Stage i sees the input stream delayed by i*STAGE_LAT cycles; stage 0 uses the port.
  always_comb begin
    v_stg    = '0;
    l_stg    = '0;
    v_stg[0] = in_valid;
    l_stg[0] = in_valid & in_last;
    for (int i = 1; i < STAGE_CNT; i++) begin
      v_stg[i] = v_dly[i*STAGE_LAT-1];
      l_stg[i] = v_dly[i*STAGE_LAT-1] & l_dly[i*STAGE_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_dly      <= '0;
      l_dly      <= '0;
      rom_addr   <= '0;
      addr_valid <= '0;
      poly_done  <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < STAGE_CNT; i++) cnt_q[i] <= '0;
    end else begin
      v_dly[0] <= in_valid;
      l_dly[0] <= in_valid & in_last;
      for (int k = 1; k < DLY; k++) begin
        v_dly[k] <= v_dly[k-1];
        l_dly[k] <= l_dly[k-1];
      end
      addr_valid <= v_stg;
      // Butterfly pair index 2*cnt+lane, coarsened to this stage's zeta granularity.
      for (int i = 0; i < STAGE_CNT; i++) begin
        if (v_stg[i]) begin
          rom_addr[0][i] <= AW'({cnt_q[i], 1'b0} >> (AW - i));
          rom_addr[1][i] <= AW'({cnt_q[i], 1'b1} >> (AW - i));
          cnt_q[i]       <= (l_stg[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
        end
      end
      // Early last or missing last at stage 0; later stages resync on the same beats.
      frame_err <= in_valid & (in_last ^ (cnt_q[0] == CNT_MAX));
      poly_done <= l_stg[STAGE_CNT-1];
    end
  end

endmodule
